cache_access_arbiter: RTL
=========================

CACHE_ACCESS_ARBITER -- requirements
Module: cache_access_arbiter

Interface
REQ-001 SHALL have parameter NUM_CORES, 4, number of requesting cores (2..8).
REQ-002 SHALL have parameter ADDR_W, 32, request address width.
REQ-003 SHALL have parameter CNT_W, 16, width of hit/miss counters.
REQ-004 SHALL have port clk  input  1  clock; all logic on rising edge.
REQ-005 SHALL have port reset  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port core_req  input  NUM_CORES  per-core access request, held until core_done.
REQ-007 SHALL have port core_addr  input  NUM_CORES*ADDR_W  per-core address; core i in slice [i*ADDR_W +: ADDR_W].
REQ-008 SHALL have port core_done  output  NUM_CORES  one-cycle completion pulse to the served core.
REQ-009 SHALL have port core_hit  output  1  hit/miss result, valid with any core_done bit.
REQ-010 SHALL have port lk_start  output  1  one-cycle pulse to start a lookup in the cache datapath.
REQ-011 SHALL have port lk_addr  output  ADDR_W  address to the datapath, held from lk_start through completion.
REQ-012 SHALL have port lk_valid  input  1  datapath lookup-result strobe.
REQ-013 SHALL have port lk_hit  input  1  lookup result, sampled when lk_valid=1.
REQ-014 SHALL have port upd_start  output  1  one-cycle pulse to write the missed line into the datapath.
REQ-015 SHALL have port upd_done  input  1  datapath write-complete strobe.
REQ-016 SHALL have port busy  output  1  high whenever the FSM is not in IDLE.
REQ-017 SHALL have port hit_count  output  CNT_W  total hits since reset.
REQ-018 SHALL have port miss_count  output  CNT_W  total misses since reset.
REQ-019 SHALL have port grant_id  output  3  index of the core currently served.

Function
REQ-020 SHALL implement an FSM with states IDLE, ISSUE, WAIT_LK, UPDATE, WAIT_UPD, RESPOND.
REQ-021 In IDLE with any core_req set, SHALL select a core by round-robin and go to ISSUE; with none set, SHALL stay in IDLE.
REQ-022 Round-robin: search starts at (last_served+1) mod NUM_CORES, wrapping past NUM_CORES-1 to 0; last_served resets to NUM_CORES-1, so core 0 wins first.
REQ-023 ISSUE SHALL last exactly one cycle, assert lk_start, latch the winner's address into lk_addr, and go to WAIT_LK.
REQ-024 WAIT_LK SHALL wait an unbounded time for lk_valid; on hit go to RESPOND, on miss go to UPDATE.
REQ-025 UPDATE SHALL last one cycle, assert upd_start, and go to WAIT_UPD; WAIT_UPD SHALL go to RESPOND on upd_done.
REQ-026 RESPOND SHALL pulse core_done[grant_id] for one cycle with core_hit = the latched lk_hit, update last_served, and return to IDLE.
REQ-027 hit_count SHALL increment in the cycle lk_valid&lk_hit is sampled; miss_count SHALL increment when lk_valid&!lk_hit is sampled.
REQ-028 Counters SHALL saturate at all-ones and never wrap.
REQ-029 lk_valid or upd_done arriving outside its wait state SHALL be ignored, with no counter or state change.
REQ-030 A requester dropping core_req mid-service SHALL NOT abort the transaction; core_done still pulses.
REQ-031 Minimum request-to-done latency (hit, lk_valid in the first WAIT_LK cycle) SHALL be 4 cycles: ISSUE, WAIT_LK, RESPOND, then core_done registered.
REQ-032 At most one transaction SHALL be outstanding; the next arbitration occurs the cycle after RESPOND.

Reset
REQ-033 Reset SHALL force IDLE; clear core_done, core_hit, lk_start, upd_start, busy, hit_count, miss_count, grant_id and lk_addr to 0; and set last_served to NUM_CORES-1.
REQ-034 Reset mid-transaction SHALL abandon the transaction without a core_done pulse; reset has priority over every other event.

Structure
REQ-035 FSM state encoding and the counter-width constant SHALL live in a shared package, cache_sim_pkg.
REQ-036 Round-robin selection SHALL be a sub-module rr_arbiter (inputs: req vector and last index; outputs: grant index and any_req).

Verification
REQ-037 core_req=4'b0001, lk_valid after 5 cycles with lk_hit=1 -> lk_start once, core_done=4'b0001, core_hit=1, hit_count=1.
REQ-038 core_req=4'b1111 held, all hits -> service order 0,1,2,3,0, and grant_id follows that order.
REQ-039 Miss on core 2 -> upd_start one cycle after lk_valid; core_done[2] only after upd_done; core_hit=0; miss_count=1.
REQ-040 Preload hit_count=16'hFFFE, then 3 hits -> hit_count stays 16'hFFFF.
REQ-041 Reset asserted in WAIT_UPD -> next cycle IDLE, busy=0, no core_done, counters 0, and core 0 is granted first afterwards.
REQ-042 Stray lk_valid in IDLE -> no state change and counters unchanged.

Source files
------------

// File: rtl/cache_sim_pkg.sv
// Shared types and constants for the cache access arbiter slice.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package cache_sim_pkg;

    // Default hit/miss counter width.
    localparam int CNT_W_DEFAULT = 16;

    // Width of a core index; sized for the largest supported core count (8).
    localparam int GRANT_W = 3;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_ISSUE    = 3'd1,
        ST_WAIT_LK  = 3'd2,
        ST_UPDATE   = 3'd3,
        ST_WAIT_UPD = 3'd4,
        ST_RESPOND  = 3'd5
    } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin picker: first requester after 'last', wrapping past NUM_CORES-1 to 0.
// Latency: combinational.
// Backpressure: none; the caller decides when to accept the grant.
// Ports: req (request vector), last (last served index) -> grant (winner index), any_req.
module rr_arbiter
    import cache_sim_pkg::*;
#(
    parameter int NUM_CORES = 4
) (
    input  logic [NUM_CORES-1:0] req,
    input  logic [GRANT_W-1:0]   last,
    output logic [GRANT_W-1:0]   grant,
    output logic                 any_req
);

    localparam int IDX_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

    logic found;
    int   idx;

    // Walk the offsets 1..NUM_CORES from 'last'; the first set bit wins.
    always_comb begin
        grant   = '0;
        any_req = |req;
        found   = 1'b0;
        idx     = 0;
        for (int k = 1; k <= NUM_CORES; k++) begin
            idx = (int'(last) + k) % NUM_CORES;
            if (!found && req[IDX_W'(idx)]) begin
                grant = GRANT_W'(idx);
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/cache_access_arbiter.sv
// Serialises per-core cache accesses onto one lookup/update datapath, round-robin.
// Latency: 4 cycles request-to-core_done on a first-cycle hit; misses add UPDATE plus the write time.
// Backpressure: one transaction at a time; other cores simply hold core_req until served.
// Ports: core_req/core_addr in, core_done/core_hit out; lk_*/upd_* to the datapath;
//        busy, grant_id and saturating hit_count/miss_count for status.
module cache_access_arbiter
    import cache_sim_pkg::*;
#(
    parameter int NUM_CORES = 4,
    parameter int ADDR_W    = 32,
    parameter int CNT_W     = CNT_W_DEFAULT
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NUM_CORES-1:0]        core_req,
    input  logic [NUM_CORES*ADDR_W-1:0] core_addr,
    output logic [NUM_CORES-1:0]        core_done,
    output logic                        core_hit,
    output logic                        lk_start,
    output logic [ADDR_W-1:0]           lk_addr,
    input  logic                        lk_valid,
    input  logic                        lk_hit,
    output logic                        upd_start,
    input  logic                        upd_done,
    output logic                        busy,
    output logic [CNT_W-1:0]            hit_count,
    output logic [CNT_W-1:0]            miss_count,
    output logic [GRANT_W-1:0]          grant_id
);

    state_t              state;
    state_t              state_nxt;
    logic [GRANT_W-1:0]  last_served;
    logic [GRANT_W-1:0]  rr_grant;
    logic                rr_any;
    logic                lk_hit_q;
    logic [ADDR_W-1:0]   addr_sel;

    rr_arbiter #(
        .NUM_CORES (NUM_CORES)
    ) u_rr (
        .req     (core_req),
        .last    (last_served),
        .grant   (rr_grant),
        .any_req (rr_any)
    );

    // Address mux for the winning core, compare-based to keep index widths exact.
    always_comb begin
        addr_sel = '0;
        for (int i = 0; i < NUM_CORES; i++) begin
            if (rr_grant == GRANT_W'(i)) begin
                addr_sel = core_addr[i*ADDR_W +: ADDR_W];
            end
        end
    end

    always_comb begin
        state_nxt = state;
        lk_start  = 1'b0;
        upd_start = 1'b0;
        busy      = (state != ST_IDLE);
        case (state)
            ST_IDLE: begin
                if (rr_any) begin
                    state_nxt = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                lk_start  = 1'b1;
                state_nxt = ST_WAIT_LK;
            end
            ST_WAIT_LK: begin
                if (lk_valid) begin
                    state_nxt = lk_hit ? ST_RESPOND : ST_UPDATE;
                end
            end
            ST_UPDATE: begin
                upd_start = 1'b1;
                state_nxt = ST_WAIT_UPD;
            end
            ST_WAIT_UPD: begin
                if (upd_done) begin
                    state_nxt = ST_RESPOND;
                end
            end
            ST_RESPOND: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_IDLE;
            last_served <= GRANT_W'(NUM_CORES - 1);
            grant_id    <= '0;
            lk_addr     <= '0;
            lk_hit_q    <= 1'b0;
            core_done   <= '0;
            core_hit    <= 1'b0;
            hit_count   <= '0;
            miss_count  <= '0;
        end else begin
            state     <= state_nxt;
            core_done <= '0;

            // Winner and its address are captured on entry to ISSUE so lk_addr
            // is already stable while lk_start is high.
            if (state == ST_IDLE && rr_any) begin
                grant_id <= rr_grant;
                lk_addr  <= addr_sel;
            end

            // lk_valid only counts in WAIT_LK; strays elsewhere are dropped here.
            if (state == ST_WAIT_LK && lk_valid) begin
                lk_hit_q <= lk_hit;
                if (lk_hit) begin
                    if (hit_count != '1) begin
                        hit_count <= hit_count + CNT_W'(1);
                    end
                end else begin
                    if (miss_count != '1) begin
                        miss_count <= miss_count + CNT_W'(1);
                    end
                end
            end

            // core_done is registered out of RESPOND, so it shows in the following IDLE cycle.
            if (state == ST_RESPOND) begin
                for (int i = 0; i < NUM_CORES; i++) begin
                    core_done[i] <= (grant_id == GRANT_W'(i));
                end
                core_hit    <= lk_hit_q;
                last_served <= grant_id;
            end
        end
    end

endmodule
